// File: rtl/imem_loader.sv
// Byte-stream loader for the MIPS pipeline: parses L/R/S/H commands, assembles little-endian
// words into instruction memory and drives the pipeline reset / clock-enable.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   input  logic              i_halt_in,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_pipe_rst,
   output logic              o_pipe_en,
   output logic              o_busy,
   output logic              o_load_done,
   output logic [15:0]       o_words_loaded,
   output logic              o_cmd_err
);

   typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_WORD, S_DONE} state_t;

   state_t            r_state, w_stateNext;
   logic              r_rxReady, w_rxReadyNext;
   logic              r_we, w_weNext;
   logic [ADDR_W-1:0] r_addr, w_addrNext;
   logic [31:0]       r_wdata, w_wdataNext;
   logic              r_pipeRst, w_pipeRstNext;
   logic              r_pipeEn, w_pipeEnNext;
   logic              r_step, w_stepNext;
   logic              r_busy, w_busyNext;
   logic              r_loadDone, w_loadDoneNext;
   logic [15:0]       r_wordsLoaded, w_wordsLoadedNext;
   logic              r_cmdErr, w_cmdErrNext;
   logic [7:0]        r_lenLo, w_lenLoNext;
   logic [15:0]       r_len, w_lenNext;
   logic [15:0]       r_left, w_leftNext;
   logic [ADDR_W-1:0] r_wordIdx, w_wordIdxNext;
   logic [1:0]        r_byteIdx, w_byteIdxNext;
   logic [23:0]       r_assembly, w_assemblyNext;

   logic              w_accept;
   logic [15:0]       w_lenFull;

   assign w_accept  = i_rx_valid & r_rxReady;
   assign w_lenFull = {i_rx_data, r_lenLo};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_rxReady     <= 1'b1;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_pipeRst     <= 1'b1;
         r_pipeEn      <= 1'b0;
         r_step        <= 1'b0;
         r_busy        <= 1'b0;
         r_loadDone    <= 1'b0;
         r_wordsLoaded <= '0;
         r_cmdErr      <= 1'b0;
         r_lenLo       <= '0;
         r_len         <= '0;
         r_left        <= '0;
         r_wordIdx     <= '0;
         r_byteIdx     <= '0;
         r_assembly    <= '0;
      end else begin
         r_state       <= w_stateNext;
         r_rxReady     <= w_rxReadyNext;
         r_we          <= w_weNext;
         r_addr        <= w_addrNext;
         r_wdata       <= w_wdataNext;
         r_pipeRst     <= w_pipeRstNext;
         r_pipeEn      <= w_pipeEnNext;
         r_step        <= w_stepNext;
         r_busy        <= w_busyNext;
         r_loadDone    <= w_loadDoneNext;
         r_wordsLoaded <= w_wordsLoadedNext;
         r_cmdErr      <= w_cmdErrNext;
         r_lenLo       <= w_lenLoNext;
         r_len         <= w_lenNext;
         r_left        <= w_leftNext;
         r_wordIdx     <= w_wordIdxNext;
         r_byteIdx     <= w_byteIdxNext;
         r_assembly    <= w_assemblyNext;
      end
   end

   // Every output is computed here one cycle ahead and registered above.
   always_comb begin
      w_stateNext       = r_state;
      w_weNext          = 1'b0;
      w_addrNext        = r_addr;
      w_wdataNext       = r_wdata;
      w_pipeRstNext     = r_pipeRst;
      w_pipeEnNext      = r_pipeEn;
      w_stepNext        = 1'b0;
      w_loadDoneNext    = 1'b0;
      w_wordsLoadedNext = r_wordsLoaded;
      w_cmdErrNext      = 1'b0;
      w_lenLoNext       = r_lenLo;
      w_lenNext         = r_len;
      w_leftNext        = r_left;
      w_wordIdxNext     = r_wordIdx;
      w_byteIdxNext     = r_byteIdx;
      w_assemblyNext    = r_assembly;

      case (r_state)
         S_IDLE: begin
            if (r_step) w_pipeEnNext = 1'b0;
            if (w_accept) begin
               case (i_rx_data)
                  8'h4C: begin
                     w_pipeEnNext  = 1'b0;
                     w_pipeRstNext = 1'b1;
                     w_stateNext   = S_LEN0;
                  end
                  8'h52: begin
                     w_pipeRstNext = 1'b0;
                     w_pipeEnNext  = 1'b1;
                  end
                  8'h53: begin
                     w_pipeRstNext = 1'b0;
                     w_pipeEnNext  = 1'b1;
                     w_stepNext    = 1'b1;
                  end
                  8'h48:   w_pipeEnNext = 1'b0;
                  default: w_cmdErrNext = 1'b1;
               endcase
            end
            // A halting pipeline wins over a run/step issued in the same cycle.
            if (i_halt_in) begin
               w_pipeEnNext = 1'b0;
               w_stepNext   = 1'b0;
            end
         end
         S_LEN0: begin
            if (w_accept) begin
               w_lenLoNext = i_rx_data;
               w_stateNext = S_LEN1;
            end
         end
         S_LEN1: begin
            if (w_accept) begin
               w_lenNext = w_lenFull;
               if (w_lenFull == 16'd0) begin
                  w_stateNext       = S_DONE;
                  w_loadDoneNext    = 1'b1;
                  w_wordsLoadedNext = 16'd0;
                  w_pipeRstNext     = 1'b0;
               end else begin
                  w_stateNext   = S_WORD;
                  w_leftNext    = w_lenFull;
                  w_wordIdxNext = '0;
                  w_byteIdxNext = '0;
               end
            end
         end
         S_WORD: begin
            if (w_accept) begin
               w_assemblyNext = {i_rx_data, r_assembly[23:8]};
               w_byteIdxNext  = r_byteIdx + 2'd1;
               if (r_byteIdx == 2'd3) begin
                  w_weNext      = 1'b1;
                  w_addrNext    = r_wordIdx;
                  w_wdataNext   = {i_rx_data, r_assembly};
                  w_wordIdxNext = r_wordIdx + ADDR_W'(1);
                  w_leftNext    = r_left - 16'd1;
                  if (r_left == 16'd1) begin
                     w_stateNext       = S_DONE;
                     w_loadDoneNext    = 1'b1;
                     w_wordsLoadedNext = r_len;
                     w_pipeRstNext     = 1'b0;
                  end
               end
            end
         end
         S_DONE:  w_stateNext = S_IDLE;
         default: w_stateNext = S_IDLE;
      endcase
   end

   assign w_rxReadyNext = (w_stateNext != S_DONE);
   assign w_busyNext    = (w_stateNext != S_IDLE);

   assign o_rx_ready     = r_rxReady;
   assign o_imem_we      = r_we;
   assign o_imem_addr    = r_addr;
   assign o_imem_wdata   = r_wdata;
   assign o_pipe_rst     = r_pipeRst;
   assign o_pipe_en      = r_pipeEn;
   assign o_busy         = r_busy;
   assign o_load_done    = r_loadDone;
   assign o_words_loaded = r_wordsLoaded;
   assign o_cmd_err      = r_cmdErr;

endmodule
